counter_edge_lib: RTL and testbench

Shared timing primitives for the delivery-game datapath: a rising-edge pulse detector, a modulo-M event counter and a saturating counter. They share one clock and one asynchronous reset. The datapath uses them to turn button presses into single-cycle moves, to divide map-move events into obstacle, objective and score ticks, and to hold a capped score. The three sections are independent and have no combinational paths between them.

---
 rtl/counter_edge_lib.sv | 92 +++++++++
 tb/tb_counter_edge_lib.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/counter_edge_lib.sv
// Timing primitives for the delivery-game datapath: a rising-edge pulse
// detector, a modulo-M event counter and a saturating counter. The three
// sections share clock and asynchronous reset but are otherwise independent.
module counter_edge_lib #(
   parameter int M     = 48,
   parameter int N     = 6,
   parameter int MAX_M = 7,
   parameter int MAX_N = 3
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             sinal,
   output logic             pulso,
   input  logic             mod_clear,
   input  logic             mod_conta,
   output logic [N-1:0]     mod_q,
   output logic             mod_fim,
   output logic             mod_meio,
   input  logic             max_clear,
   input  logic             max_conta,
   output logic [MAX_N-1:0] max_q,
   output logic             max_fim,
   output logic             max_meio
);

   // Decode constants, sized to the counter widths.
   localparam logic [N-1:0]     MOD_LAST = N'(M - 1);
   localparam logic [N-1:0]     MOD_MID  = N'(M / 2 - 1);
   localparam logic [MAX_N-1:0] MAX_TOP  = MAX_N'(MAX_M);
   localparam logic [MAX_N-1:0] MAX_MID  = MAX_N'(MAX_M / 2);

   // Next value of the modulo counter: wraps to zero after M-1.
   function automatic logic [N-1:0] mod_next(input logic [N-1:0] q);
      if (q == MOD_LAST) begin
         return '0;
      end
      return q + N'(1);
   endfunction

   // Next value of the saturating counter: sticks at MAX_M.
   function automatic logic [MAX_N-1:0] sat_next(input logic [MAX_N-1:0] q);
      if (q < MAX_TOP) begin
         return q + MAX_N'(1);
      end
      return q;
   endfunction

   logic sinal_p0;
   logic sinal_p1;

   // Edge detector delay line: two samples of sinal.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sinal_p0 <= 1'b0;
         sinal_p1 <= 1'b0;
      end else begin
         sinal_p0 <= sinal;
         sinal_p1 <= sinal_p0;
      end
   end

   assign pulso = sinal_p0 & ~sinal_p1;

   // Modulo counter: clear beats count, count wraps at M-1.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         mod_q <= '0;
      end else if (mod_clear) begin
         mod_q <= '0;
      end else if (mod_conta) begin
         mod_q <= mod_next(mod_q);
      end
   end

   assign mod_fim  = (mod_q == MOD_LAST);
   assign mod_meio = (mod_q == MOD_MID);

   // Saturating counter: clear beats count, count holds at MAX_M.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         max_q <= '0;
      end else if (max_clear) begin
         max_q <= '0;
      end else if (max_conta) begin
         max_q <= sat_next(max_q);
      end
   end

   assign max_fim  = (max_q == MAX_TOP);
   assign max_meio = (max_q == MAX_MID);

endmodule

// File: tb/tb_counter_edge_lib.sv
// Self-checking bench for counter_edge_lib: directed phases with literal
// expectations, then randomized traffic checked against an arithmetic model.
module tb_counter_edge_lib;
   localparam int M     = 48;
   localparam int N     = 6;
   localparam int MAX_M = 7;
   localparam int MAX_N = 3;

   logic             clock = 1'b0;
   logic             reset;
   logic             sinal;
   logic             pulso;
   logic             mod_clear;
   logic             mod_conta;
   logic [N-1:0]     mod_q;
   logic             mod_fim;
   logic             mod_meio;
   logic             max_clear;
   logic             max_conta;
   logic [MAX_N-1:0] max_q;
   logic             max_fim;
   logic             max_meio;

   counter_edge_lib #(.M(M), .N(N), .MAX_M(MAX_M), .MAX_N(MAX_N)) dut (
      .clock(clock), .reset(reset), .sinal(sinal), .pulso(pulso),
      .mod_clear(mod_clear), .mod_conta(mod_conta), .mod_q(mod_q),
      .mod_fim(mod_fim), .mod_meio(mod_meio),
      .max_clear(max_clear), .max_conta(max_conta), .max_q(max_q),
      .max_fim(max_fim), .max_meio(max_meio)
   );

   always #5 clock = ~clock;

   int checks = 0;
   int errors = 0;

   // Model: last two sampled sinal values and the two counter values.
   int m_last, m_prev, m_mod, m_max;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_last = 0; m_prev = 0; m_mod = 0; m_max = 0;
   endtask

   task automatic compare_model();
      chk("pulso",    32'(pulso),    32'((m_last == 1 && m_prev == 0) ? 1 : 0));
      chk("mod_q",    32'(mod_q),    32'(m_mod));
      chk("mod_fim",  32'(mod_fim),  32'((m_mod == M - 1) ? 1 : 0));
      chk("mod_meio", 32'(mod_meio), 32'((m_mod == M / 2 - 1) ? 1 : 0));
      chk("max_q",    32'(max_q),    32'(m_max));
      chk("max_fim",  32'(max_fim),  32'((m_max == MAX_M) ? 1 : 0));
      chk("max_meio", 32'(max_meio), 32'((m_max == MAX_M / 2) ? 1 : 0));
   endtask

   // One clock: advance the model with the inputs sampled at the edge, then compare.
   task automatic cycle();
      @(posedge clock);
      if (!reset) begin
         m_prev = m_last;
         m_last = int'(sinal);
         if (mod_clear) m_mod = 0;
         else if (mod_conta) m_mod = (m_mod + 1) % M;
         if (max_clear) m_max = 0;
         else if (max_conta && m_max < MAX_M) m_max = m_max + 1;
      end
      #1;
      compare_model();
   endtask

   task automatic pulse_reset();
      reset = 1'b1;
      #1;
      model_reset();
      compare_model();
      reset = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int fim_cnt;
      reset = 1'b1; sinal = 1'b0;
      mod_clear = 1'b0; mod_conta = 1'b0; max_clear = 1'b0; max_conta = 1'b0;
      model_reset();
      #2;
      chk("rst_pulso", 32'(pulso), 0);
      chk("rst_mod_q", 32'(mod_q), 0);
      chk("rst_mod_fim", 32'(mod_fim), 0);
      chk("rst_mod_meio", 32'(mod_meio), 0);
      chk("rst_max_q", 32'(max_q), 0);
      chk("rst_max_fim", 32'(max_fim), 0);
      chk("rst_max_meio", 32'(max_meio), 0);
      reset = 1'b0;

      // Held-high input gives one pulse in the first cycle only.
      sinal = 1'b1;
      for (int i = 0; i < 5; i++) begin
         cycle();
         chk("held_pulse", 32'(pulso), (i == 0) ? 1 : 0);
      end
      sinal = 1'b0;
      cycle(); cycle();

      // Toggling 1,0,1,0: pulses two cycles apart.
      for (int i = 0; i < 4; i++) begin
         sinal = (i % 2 == 0);
         cycle();
         chk("toggle_pulse", 32'(pulso), (i % 2 == 0) ? 1 : 0);
      end
      sinal = 1'b0;

      // Modulo wrap over 100 enabled cycles.
      pulse_reset();
      mod_conta = 1'b1;
      fim_cnt = 0;
      for (int i = 0; i < 100; i++) begin
         if (mod_fim) fim_cnt++;
         if (mod_meio) chk("meio_at_23", 32'(mod_q), 23);
         cycle();
      end
      chk("wrap_fim_count", 32'(fim_cnt), 2);
      chk("wrap_final_q", 32'(mod_q), 4);

      // Clear, count to 10, then clear+count together.
      mod_clear = 1'b1; mod_conta = 1'b0; cycle();
      mod_clear = 1'b0; mod_conta = 1'b1;
      for (int i = 0; i < 10; i++) cycle();
      chk("count_to_10", 32'(mod_q), 10);
      mod_clear = 1'b1; cycle();
      chk("clear_wins", 32'(mod_q), 0);
      mod_clear = 1'b0;
      cycle(); cycle(); cycle();
      mod_conta = 1'b0;
      cycle(); cycle();
      chk("mod_hold", 32'(mod_q), 3);

      // Saturation: 12 pulses, then clear.
      max_clear = 1'b1; cycle(); max_clear = 1'b0;
      for (int k = 1; k <= 12; k++) begin
         max_conta = 1'b1; cycle();
         chk("sat_q", 32'(max_q), (k < 7) ? k : 7);
         chk("sat_fim", 32'(max_fim), (k >= 7) ? 1 : 0);
         chk("sat_meio", 32'(max_meio), (k == 3) ? 1 : 0);
         max_conta = 1'b0; cycle();
      end
      max_clear = 1'b1; cycle(); max_clear = 1'b0;
      chk("sat_cleared", 32'(max_q), 0);

      // Asynchronous reset mid-count and mid-pulse.
      mod_clear = 1'b1; cycle(); mod_clear = 1'b0;
      mod_conta = 1'b1; max_conta = 1'b1;
      for (int i = 0; i < 20; i++) begin
         if (i == 5) max_conta = 1'b0;
         if (i == 19) sinal = 1'b1;
         cycle();
      end
      mod_conta = 1'b0;
      chk("pre_rst_mod", 32'(mod_q), 20);
      chk("pre_rst_max", 32'(max_q), 5);
      chk("pre_rst_pulso", 32'(pulso), 1);
      #2;
      reset = 1'b1;
      #1;
      model_reset();
      chk("async_mod_q", 32'(mod_q), 0);
      chk("async_max_q", 32'(max_q), 0);
      chk("async_pulso", 32'(pulso), 0);
      chk("async_max_meio", 32'(max_meio), 0);
      compare_model();
      reset = 1'b0;
      // sinal still high at reset release: exactly one new pulse.
      cycle();
      chk("post_rst_pulse", 32'(pulso), 1);
      cycle();
      chk("post_rst_no_pulse", 32'(pulso), 0);

      // Randomized traffic with occasional asynchronous resets.
      for (int i = 0; i < 2000; i++) begin
         sinal     = ($urandom_range(0, 2) == 0);
         mod_clear = ($urandom_range(0, 63) == 0);
         mod_conta = ($urandom_range(0, 3) != 0);
         max_clear = ($urandom_range(0, 31) == 0);
         max_conta = ($urandom_range(0, 1) == 0);
         cycle();
         if ($urandom_range(0, 99) == 0) pulse_reset();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
